// File: rtl/reg_files_pkg.sv
// rtl/reg_files_pkg.sv - shared widths, types and constants for the register file
package reg_files_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_files_rd_port.sv
// rtl/reg_files_rd_port.sv - one asynchronous read port with zero-register check
// REGFILE_WB_BYPASS_EN adds a write-through bypass from wb_data when addr matches rwd.
module reg_files_rd_port
   import reg_files_pkg::*;
(
   input  logic              RST,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] rwd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] rf_word,
   output logic [DATA_W-1:0] val
);

   logic hit;

`ifdef REGFILE_WB_BYPASS_EN
   // Forward the value being written back so decode sees it on the same edge.
   assign hit = !RST && (rwd != REG_ZERO) && (addr == rwd);
`else
   logic unused_bypass;
   assign unused_bypass = ^{RST, rwd};
   assign hit = 1'b0;
`endif

   always_comb begin
      if (addr == REG_ZERO)
         val = '0;
      else if (hit)
         val = wb_data;
      else
         val = rf_word;
   end

endmodule

// File: rtl/reg_files.sv
// rtl/reg_files.sv - 32x32 general-purpose register file, two async reads, one sync write
// R0 reads as zero; rwd == 0 encodes "no write".
module reg_files
   import reg_files_pkg::*;
(
   input  logic                CLK,
   input  logic                RST,
   input  logic [2*ADDR_W-1:0] rs_rt,
   input  logic [ADDR_W-1:0]   rwd,
   input  logic [DATA_W-1:0]   wb_data,
   output logic [DATA_W-1:0]   val_rs,
   output logic [DATA_W-1:0]   val_rt
);

   word_t     regs [NUM_REGS];
   reg_addr_t rs_addr;
   reg_addr_t rt_addr;

   assign rs_addr = rs_rt[2*ADDR_W-1:ADDR_W];
   assign rt_addr = rs_rt[ADDR_W-1:0];

   // R0 is cleared on reset and never written, so it stays defined at zero.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (rwd != REG_ZERO) begin
         regs[rwd] <= wb_data;
      end
   end

   reg_files_rd_port u_rd_rs (
      .RST     (RST),
      .addr    (rs_addr),
      .rwd     (rwd),
      .wb_data (wb_data),
      .rf_word (regs[rs_addr]),
      .val     (val_rs)
   );

   reg_files_rd_port u_rd_rt (
      .RST     (RST),
      .addr    (rt_addr),
      .rwd     (rwd),
      .wb_data (wb_data),
      .rf_word (regs[rt_addr]),
      .val     (val_rt)
   );

endmodule

// File: tb/tb_reg_files.sv
// tb/tb_reg_files.sv - randomized self-checking bench for reg_files against an array model
// Expectations follow REGFILE_WB_BYPASS_EN when it is defined.
module tb_reg_files;

   logic        CLK;
   logic        RST;
   logic [9:0]  rs_rt;
   logic [4:0]  rwd;
   logic [31:0] wb_data;
   logic [31:0] val_rs;
   logic [31:0] val_rt;

   logic [31:0] model [32];
   int          n_checks;
   int          n_pass;

   reg_files dut (
      .CLK     (CLK),
      .RST     (RST),
      .rs_rt   (rs_rt),
      .rwd     (rwd),
      .wb_data (wb_data),
      .val_rs  (val_rs),
      .val_rt  (val_rt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Value a read port should show right now, from the architectural rules.
   function automatic logic [31:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (RST) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
      if (rwd != 5'd0 && a == rwd) return wb_data;
`endif
      return model[a];
   endfunction

   // Advance one clock edge, applying the current write to the model.
   task automatic step();
      @(posedge CLK);
      if (!RST && rwd != 5'd0) model[rwd] = wb_data;
      #2;
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
      rwd = a;
      wb_data = d;
      step();
      rwd = 5'd0;
      wb_data = 32'h0;
   endtask

   task automatic check_both(input string tag, input logic [4:0] a, input logic [4:0] b);
      rs_rt = {a, b};
      #1;
      check({tag, "_rs"}, val_rs, exp_read(a));
      check({tag, "_rt"}, val_rt, exp_read(b));
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      RST = 1'b1;
      rs_rt = 10'h0;
      rwd = 5'd0;
      wb_data = 32'h0;
      #12;
      RST = 1'b0;
      step();

      for (int i = 0; i < 32; i++) begin
         rs_rt = {i[4:0], 5'(31 - i)};
         #1;
         check("reset_rs", val_rs, 32'h0);
         check("reset_rt", val_rt, 32'h0);
      end

      // Write then read through both ports.
      write_reg(5'd3, 32'h12345678);
      rs_rt = {5'd3, 5'd3};
      #1;
      check("wr3_rs", val_rs, 32'h12345678);
      check("wr3_rt", val_rt, 32'h12345678);

      // R0 protection.
      write_reg(5'd0, 32'hFFFFFFFF);
      rs_rt = {5'd0, 5'd3};
      #1;
      check("r0_rs", val_rs, 32'h0);
      check("r0_keep3", val_rt, 32'h12345678);
      rwd = 5'd0;
      wb_data = 32'hFFFFFFFF;
      check_both("r0_live", 5'd0, 5'd0);
      wb_data = 32'h0;

      // Dual port and swap.
      write_reg(5'd7, 32'hA5A5A5A5);
      write_reg(5'd31, 32'h5A5A5A5A);
      rs_rt = {5'd7, 5'd31};
      #1;
      check("dual_rs", val_rs, 32'hA5A5A5A5);
      check("dual_rt", val_rt, 32'h5A5A5A5A);
      rs_rt = {5'd31, 5'd7};
      #1;
      check("swap_rs", val_rs, 32'h5A5A5A5A);
      check("swap_rt", val_rt, 32'hA5A5A5A5);

      // Read during write on R9.
      write_reg(5'd9, 32'h1);
      rwd = 5'd9;
      wb_data = 32'h2;
      rs_rt = {5'd9, 5'd0};
      #1;
`ifdef REGFILE_WB_BYPASS_EN
      check("rdw_before", val_rs, 32'h2);
`else
      check("rdw_before", val_rs, 32'h1);
`endif
      step();
      rwd = 5'd0;
      wb_data = 32'h0;
      #1;
      check("rdw_after", val_rs, 32'h2);

      // Asynchronous reset mid-cycle.
      write_reg(5'd5, 32'hDEADBEEF);
      rs_rt = {5'd5, 5'd5};
      #1;
      check("pre_rst", val_rs, 32'hDEADBEEF);
      RST = 1'b1;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      #1;
      check("async_rst_rs", val_rs, 32'h0);
      check("async_rst_rt", val_rt, 32'h0);
      // Writes and bypass are blocked while reset is held across an edge.
      rwd = 5'd5;
      wb_data = 32'hCAFEF00D;
      #1;
      check("rst_nobypass", val_rs, 32'h0);
      step();
      rwd = 5'd0;
      wb_data = 32'h0;
      RST = 1'b0;
      #1;
      check("rst_nowrite", val_rs, 32'h0);

      // Sweep R1..R31.
      for (int i = 1; i < 32; i++) write_reg(i[4:0], 32'h100 + i);
      for (int i = 0; i < 32; i++) begin
         rs_rt = {i[4:0], i[4:0]};
         #1;
         check("sweep_rs", val_rs, (i == 0) ? 32'h0 : 32'h100 + i);
         check("sweep_rt", val_rt, (i == 0) ? 32'h0 : 32'h100 + i);
      end

      // Randomized traffic with reads before each edge.
      for (int n = 0; n < 400; n++) begin
         rwd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wb_data = $urandom;
         if ($urandom_range(0, 3) == 0)
            check_both("rand_hit", rwd, 5'($urandom_range(0, 31)));
         else
            check_both("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         step();
      end
      rwd = 5'd0;
      wb_data = 32'h0;
      for (int i = 0; i < 32; i++) check_both("final", i[4:0], 5'(31 - i));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
